sum3_sched: RTL and testbench

SUM3_SCHED -- requirements
Module: sum3_sched

---
 rtl/sum3_sched_if.sv | 28 ++
 rtl/sum3_sched.sv | 93 +++++++++
 tb/tb_sum3_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sum3_sched_if.sv
// sum3_sched_if: requester, datapath and response signals of sum3_sched.
// slave is the scheduler's view; master is the surrounding environment's view.
interface sum3_sched_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int OW   = 10
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_data;
    logic               dp_i_dval;
    logic [DW-1:0]      dp_i;
    logic               dp_o_dval;
    logic [OW-1:0]      dp_o;
    logic               rsp_valid;
    logic [IW-1:0]      rsp_id;
    logic [OW-1:0]      rsp_data;
    logic               err;
    modport slave (
        input  req_valid, req_data, dp_o_dval, dp_o,
        output req_ready, dp_i_dval, dp_i, rsp_valid, rsp_id, rsp_data, err
    );
    modport master (
        output req_valid, req_data, dp_o_dval, dp_o,
        input  req_ready, dp_i_dval, dp_i, rsp_valid, rsp_id, rsp_data, err
    );
endinterface

// File: rtl/sum3_sched.sv
// sum3_sched: shares one sum-every-3 datapath among NREQ requesters and routes sums back by tag.
// Define SUM3_SCHED_FIXED_PRIO_EN for lowest-index-first arbitration instead of round-robin.
module sum3_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int OW   = 10
) (
    input logic clk,
    input logic rst,
    sum3_sched_if.slave bus
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nxt;
    logic [1:0] count;
    logic [IW-1:0] grant, ptr, arb, grant_inc;
    logic [IW-1:0] tags [4];
    logic [1:0] wptr, rptr;
    logic [2:0] occ;
    logic found, accept, last, full, empty, pop;
    int idx;
    // With ptr held at 0 the rotating search degenerates to fixed priority.
    always_comb begin
        arb = '0;
        found = 1'b0;
        idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                arb = IW'(idx);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        full = occ == 3'd4;
        empty = occ == 3'd0;
        accept = state == BURST && bus.req_valid[grant];
        last = accept && count == 2'd2;
        pop = bus.dp_o_dval && !empty;
        grant_inc = grant == IW'(NREQ - 1) ? '0 : grant + 1'b1;
        state_nxt = state == IDLE ? (found && !full ? BURST : IDLE) : (last ? IDLE : BURST);
        bus.req_ready = state == BURST ? NREQ'(1) << grant : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge clk) begin
        if (last) tags[wptr] <= grant;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            grant <= '0;
            ptr <= '0;
            wptr <= '0;
            rptr <= '0;
            occ <= '0;
            bus.dp_i_dval <= 1'b0;
            bus.dp_i <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id <= '0;
            bus.rsp_data <= '0;
            bus.err <= 1'b0;
        end else begin
            if (state == IDLE && state_nxt == BURST) begin
                grant <= arb;
                count <= '0;
            end else if (accept) begin
                count <= last ? 2'd0 : count + 2'd1;
            end
            bus.dp_i_dval <= accept;
            if (accept) bus.dp_i <= bus.req_data[int'(grant)*DW +: DW];
            if (last) begin
                wptr <= wptr + 2'd1;
`ifdef SUM3_SCHED_FIXED_PRIO_EN
                ptr <= '0;
`else
                ptr <= grant_inc;
`endif
            end
            if (pop) rptr <= rptr + 2'd1;
            occ <= occ + 3'(last) - 3'(pop);
            bus.rsp_valid <= pop;
            if (pop) begin
                bus.rsp_id <= tags[rptr];
                bus.rsp_data <= bus.dp_o;
            end
            bus.err <= bus.err | (bus.dp_o_dval & empty);
        end
    end
endmodule

// File: tb/tb_sum3_sched.sv
// tb_sum3_sched: directed vector table plus hand-written multi-cycle sequences for sum3_sched.
module tb_sum3_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    sum3_sched_if #(.NREQ(4), .DW(8), .OW(10)) bus ();
    sum3_sched #(.NREQ(4), .DW(8), .OW(10)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    // {req_ready, dp_i_dval, dp_i, rsp_valid, rsp_id, rsp_data, err}
    logic [26:0] outs;
    assign outs = {bus.req_ready, bus.dp_i_dval, bus.dp_i, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.err};
    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic        odv;
        logic [9:0]  o;
        logic [26:0] exp;
    } vec_t;
    vec_t tbl [8];
    logic [3:0] exp_g [4];
    logic [1:0] exp_id [4];

    function automatic logic [26:0] e(input logic [3:0] rdy, input logic dv, input logic [7:0] di,
                                      input logic rv, input logic [1:0] rid, input logic [9:0] rd, input logic er);
        return {rdy, dv, di, rv, rid, rd, er};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.dp_o_dval = 1'b0;
        bus.dp_o = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 30 && bus.req_ready == '0; n++) tick();
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 30 && bus.req_ready != '0; n++) tick();
    endtask

    initial begin
        logic seen;
`ifdef SUM3_SCHED_FIXED_PRIO_EN
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
        exp_id = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
        exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        exp_id = '{2'd2, 2'd0, 2'd2, 2'd0};
`endif
        // Requester 1 sends 10,20,30; datapath answers 60.
        tbl[0] = '{4'b0010, 32'h0A00, 1'b0, 10'd0,  e(4'b0000, 0, 8'd0,  0, 2'd0, 10'd0,  0)};
        tbl[1] = '{4'b0010, 32'h0A00, 1'b0, 10'd0,  e(4'b0010, 0, 8'd0,  0, 2'd0, 10'd0,  0)};
        tbl[2] = '{4'b0010, 32'h1400, 1'b0, 10'd0,  e(4'b0010, 1, 8'd10, 0, 2'd0, 10'd0,  0)};
        tbl[3] = '{4'b0010, 32'h1E00, 1'b0, 10'd0,  e(4'b0010, 1, 8'd20, 0, 2'd0, 10'd0,  0)};
        tbl[4] = '{4'b0000, 32'h0000, 1'b0, 10'd0,  e(4'b0000, 1, 8'd30, 0, 2'd0, 10'd0,  0)};
        tbl[5] = '{4'b0000, 32'h0000, 1'b1, 10'd60, e(4'b0000, 0, 8'd30, 0, 2'd0, 10'd0,  0)};
        tbl[6] = '{4'b0000, 32'h0000, 1'b0, 10'd0,  e(4'b0000, 0, 8'd30, 1, 2'd1, 10'd60, 0)};
        tbl[7] = '{4'b0000, 32'h0000, 1'b0, 10'd0,  e(4'b0000, 0, 8'd30, 0, 2'd1, 10'd60, 0)};

        do_reset();
        chk("reset_state", 64'(outs), 64'd0);
        for (int i = 0; i < 8; i++) begin
            bus.req_valid = tbl[i].v;
            bus.req_data = tbl[i].d;
            bus.dp_o_dval = tbl[i].odv;
            bus.dp_o = tbl[i].o;
            chk($sformatf("vec%0d", i), 64'(outs), 64'(tbl[i].exp));
            tick();
        end

        // Requesters 0 and 2 always valid: arbitration order, then full-FIFO blocking.
        do_reset();
        bus.req_valid = 4'b0101;
        bus.req_data = 32'h0003_0001;
        for (int g = 0; g < 4; g++) begin
            wait_ready();
            chk($sformatf("grant%0d", g), 64'(bus.req_ready), 64'(exp_g[g]));
            wait_idle();
        end
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (bus.req_ready != '0) seen = 1'b1;
        end
        chk("fifth_blocked", 64'(seen), 64'd0);
        bus.dp_o_dval = 1'b1;
        bus.dp_o = 10'd100;
        tick();
        bus.dp_o_dval = 1'b0;
        chk("pop_first", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_data}), 64'({1'b1, 2'd0, 10'd100}));
        wait_ready();
        chk("fifth_grant", 64'(bus.req_ready), 64'd1);
        wait_idle();
        bus.req_valid = '0;
        bus.dp_o_dval = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.dp_o = 10'(200 + k);
            tick();
            chk($sformatf("drain%0d", k), 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_data}),
                64'({1'b1, exp_id[k], 10'(200 + k)}));
        end
        bus.dp_o_dval = 1'b0;
        tick();
        chk("drained_quiet", 64'({bus.rsp_valid, bus.err}), 64'd0);

        // Requester 3 stalls after its first beat.
        do_reset();
        bus.req_valid = 4'b1000;
        bus.req_data = 32'h0500_0000;
        tick();
        chk("stall_grant", 64'(bus.req_ready), 64'b1000);
        tick();
        bus.req_valid = '0;
        chk("stall_beat1", 64'({bus.dp_i_dval, bus.dp_i}), 64'({1'b1, 8'd5}));
        for (int n = 0; n < 5; n++) begin
            tick();
            chk($sformatf("stall%0d", n), 64'({bus.req_ready, bus.dp_i_dval}), 64'({4'b1000, 1'b0}));
        end
        bus.req_valid = 4'b1000;
        bus.req_data = 32'h0600_0000;
        tick();
        bus.req_data = 32'h0700_0000;
        chk("stall_beat2", 64'({bus.dp_i_dval, bus.dp_i}), 64'({1'b1, 8'd6}));
        tick();
        bus.req_valid = '0;
        chk("stall_beat3", 64'({bus.req_ready, bus.dp_i_dval, bus.dp_i}), 64'({4'b0000, 1'b1, 8'd7}));
        tick();
        chk("stall_done", 64'(bus.dp_i_dval), 64'd0);

        // Unexpected datapath result sets a sticky error.
        do_reset();
        bus.dp_o_dval = 1'b1;
        bus.dp_o = 10'd5;
        tick();
        bus.dp_o_dval = 1'b0;
        chk("err_set", 64'({bus.err, bus.rsp_valid}), 64'b10);
        repeat (3) tick();
        chk("err_sticky", 64'({bus.err, bus.rsp_valid}), 64'b10);
        do_reset();
        chk("err_cleared", 64'(bus.err), 64'd0);

        // Reset after beat 2 abandons the group without a tag.
        bus.req_valid = 4'b0001;
        bus.req_data = 32'h09;
        repeat (3) tick();
        chk("mid_burst_pre", 64'({bus.req_ready, bus.dp_i_dval, bus.dp_i}), 64'({4'b0001, 1'b1, 8'd9}));
        rst = 1'b1;
        bus.req_valid = '0;
        #1;
        chk("rst_mid_burst", 64'(outs), 64'd0);
        tick();
        rst = 1'b0;
        bus.dp_o_dval = 1'b1;
        tick();
        bus.dp_o_dval = 1'b0;
        chk("err_after_rst", 64'({bus.err, bus.rsp_valid}), 64'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
